// File: rtl/inst_encoder_loader_if.sv
// ============================================================================
// Module      : inst_encoder_loader_if
// Description : Descriptor-in / instruction-memory-write bus for the encoder
//               loader; slave = loader view, master = driver/memory view.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface inst_encoder_loader_if #(
   parameter int ADDR_W = 8
);
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic              in_valid;
   logic              in_ready;
   logic [2:0]        in_kind;
   logic [4:0]        in_rs;
   logic [4:0]        in_rt;
   logic [4:0]        in_rd;
   logic [4:0]        in_shamt;
   logic [5:0]        in_func;
   logic [15:0]       in_imm;
   logic              imem_wr_en;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              imem_ready;
   logic [ADDR_W:0]   count;
   logic              full;
   logic              bad_kind;

   modport slave (
      input  start, base_addr, in_valid, in_kind, in_rs, in_rt, in_rd,
             in_shamt, in_func, in_imm, imem_ready,
      output in_ready, imem_wr_en, imem_addr, imem_wdata, count, full, bad_kind
   );

   modport master (
      output start, base_addr, in_valid, in_kind, in_rs, in_rt, in_rd,
             in_shamt, in_func, in_imm, imem_ready,
      input  in_ready, imem_wr_en, imem_addr, imem_wdata, count, full, bad_kind
   );
endinterface

`default_nettype wire

// File: rtl/inst_encoder_loader.sv
// ============================================================================
// Module      : inst_encoder_loader
// Description : Packs field-level instruction descriptors into 32-bit MIPS
//               words and writes them to consecutive instruction-memory words.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module inst_encoder_loader #(
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 256
) (
   input  wire logic             clk,
   input  wire logic             rst,
   inst_encoder_loader_if.slave  bus
);
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_FULL = 2'd2
   } state_t;

   localparam logic [ADDR_W:0]   c_DEPTH   = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W+1:0] c_DEPTH_X = (ADDR_W+2)'(DEPTH);

   state_t            r_state;
   logic [ADDR_W-1:0] r_ptr;
   logic [ADDR_W:0]   r_count;
   logic              r_full;
   logic              r_bad;
   logic              r_wr_en;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata;

   logic              w_accept;
   logic              w_complete;
   logic              w_legal;
   logic [31:0]       w_enc;
   logic [ADDR_W-1:0] w_ptr_inc;
   logic [ADDR_W:0]   w_count_inc;
   logic [ADDR_W+1:0] w_occupancy;
   logic              w_in_ready;

   always_comb begin
      w_legal = 1'b1;
      w_enc   = 32'h0;
      case (bus.in_kind)
         3'd0: w_enc = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, bus.in_shamt, bus.in_func};
         3'd1: w_enc = {6'b001000, bus.in_rs, bus.in_rt, bus.in_imm};
         3'd2: w_enc = {6'b100011, bus.in_rs, bus.in_rt, bus.in_imm};
         3'd3: w_enc = {6'b101011, bus.in_rs, bus.in_rt, bus.in_imm};
         3'd4: w_enc = {6'b000100, bus.in_rs, bus.in_rt, bus.in_imm};
         3'd5: w_enc = {6'b000101, bus.in_rs, bus.in_rt, bus.in_imm};
         default: w_legal = 1'b0;
      endcase
   end

   // The pending write counts against DEPTH so the last slot is never overbooked.
   assign w_occupancy = {1'b0, r_count} + {{(ADDR_W+1){1'b0}}, r_wr_en};
   assign w_in_ready  = (r_state == ST_LOAD) && !bus.start &&
                        (!r_wr_en || bus.imem_ready) && (w_occupancy < c_DEPTH_X);
   assign w_accept    = bus.in_valid && w_in_ready;
   assign w_complete  = r_wr_en && bus.imem_ready;
   assign w_ptr_inc   = r_ptr + ADDR_W'(1);
   assign w_count_inc = r_count + (ADDR_W+1)'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_ptr   <= '0;
         r_count <= '0;
         r_full  <= 1'b0;
         r_bad   <= 1'b0;
         r_wr_en <= 1'b0;
         r_addr  <= '0;
         r_wdata <= 32'h0;
      end else if (bus.start) begin
         r_state <= ST_LOAD;
         r_ptr   <= bus.base_addr;
         r_count <= '0;
         r_full  <= 1'b0;
         r_bad   <= 1'b0;
         r_wr_en <= 1'b0;
      end else begin
         if (w_complete) begin
            r_ptr   <= w_ptr_inc;
            r_count <= w_count_inc;
            if (w_count_inc == c_DEPTH) begin
               r_state <= ST_FULL;
               r_full  <= 1'b1;
            end
         end
         if (w_accept && w_legal) begin
            r_wr_en <= 1'b1;
            r_addr  <= w_complete ? w_ptr_inc : r_ptr;
            r_wdata <= w_enc;
         end else begin
            if (w_accept) r_bad <= 1'b1;
            if (w_complete) r_wr_en <= 1'b0;
         end
      end
   end

   assign bus.in_ready   = w_in_ready;
   assign bus.imem_wr_en = r_wr_en;
   assign bus.imem_addr  = r_addr;
   assign bus.imem_wdata = r_wdata;
   assign bus.count      = r_count;
   assign bus.full       = r_full;
   assign bus.bad_kind   = r_bad;

endmodule

`default_nettype wire

// File: doc/inst_encoder_loader.md
Name: inst_encoder_loader

Overview:
Write-side counterpart of the instruction control decoder. The block accepts field-level instruction descriptions over a valid/ready handshake and packs each one into a 32-bit MIPS-subset word. Each packed word is written into instruction memory at consecutive word addresses. It runs the program-load phase before the datapath fetches and decodes.

Parameters:
ADDR_W, 8, instruction-memory word-address width
DEPTH, 256, maximum words written per load session (1..2^ADDR_W)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
start  input  1  begin a new load session; one-cycle pulse
base_addr  input  ADDR_W  first word address of the session, sampled on start
in_valid  input  1  instruction descriptor valid
in_ready  output  1  descriptor accepted when in_valid && in_ready
in_kind  input  3  0 RTYPE, 1 ADDI, 2 LW, 3 SW, 4 BEQ, 5 BNE, 6-7 illegal
in_rs  input  5  rs field
in_rt  input  5  rt field
in_rd  input  5  rd field (RTYPE only)
in_shamt  input  5  shamt field (RTYPE only)
in_func  input  6  func field (RTYPE only)
in_imm  input  16  immediate / branch offset (non-RTYPE)
imem_wr_en  output  1  write request to instruction memory
imem_addr  output  ADDR_W  write word address
imem_wdata  output  32  encoded instruction
imem_ready  input  1  memory accepts the write when imem_wr_en && imem_ready
count  output  ADDR_W+1  words written this session
full  output  1  DEPTH words written; no further accepts
bad_kind  output  1  sticky; an illegal kind was received this session

Behaviour:
- Reset values:
  - state IDLE; in_ready=0, imem_wr_en=0, imem_addr=0, imem_wdata=0.
  - count=0, full=0, bad_kind=0, write pointer=0, hold register empty.
- States:
  - IDLE: no accepts.
  - LOAD: accepting descriptors.
  - FULL: session complete, no accepts.
- Transitions:
  - start from any state -> LOAD the next cycle.
  - Same edge: pointer=base_addr, count=0, full=0, bad_kind=0, pending hold register discarded.
  - start takes priority over any same-cycle accept or write completion.
  - LOAD -> FULL on the edge where count becomes DEPTH; full=1.
  - FULL -> LOAD only via start.
- Encoding, fields concatenated MSB first:
  - RTYPE: {6'b000000, rs, rt, rd, shamt, func}.
  - ADDI: {6'b001000, rs, rt, imm}.
  - LW: {6'b100011, rs, rt, imm}.
  - SW: {6'b101011, rs, rt, imm}.
  - BEQ: {6'b000100, rs, rt, imm}.
  - BNE: {6'b000101, rs, rt, imm}.
  - Fields not used by the kind are ignored.
- in_ready = (state==LOAD) && !start && (!hold_valid || imem_ready) && (count + hold_valid < DEPTH).
- Latency:
  - A descriptor accepted at edge N is presented with imem_wr_en=1 in cycle N+1.
  - imem_addr = pointer and imem_wdata = encoded word are registered together.
- Write completion:
  - imem_wr_en && imem_ready at an edge: pointer+1 (wraps modulo 2^ADDR_W), count+1.
  - hold_valid clears unless a new descriptor is accepted on the same edge.
  - Simultaneous completion and accept sustains 1 word/cycle.
- Backpressure: while imem_wr_en && !imem_ready, imem_addr, imem_wdata and imem_wr_en hold stable and in_ready=0.
- Illegal kind (6, 7):
  - The descriptor is consumed.
  - bad_kind sets; no write is issued; pointer and count are unchanged.
- imem_wr_en is never asserted in IDLE.
- imem_wr_en is never asserted after start until a new accept.
- rst mid-session: the pending write is dropped and all reset values are restored.

Test Plan:
- Reset/idle: assert rst 2 cycles, then hold in_valid=1 for 5 cycles with no start -> in_ready=0, imem_wr_en=0, count=0 throughout.
- RTYPE/ADDI encode:
  - Stimulus: start base_addr=0x10; RTYPE rs=1 rt=2 rd=3 shamt=0 func=0x20, then ADDI rs=0 rt=9 imm=0x0005; imem_ready=1.
  - Response: writes 0x00221820@0x10, then 0x20090005@0x11, back-to-back; count=2.
- Memory ops and branch:
  - Stimulus: LW rs=29 rt=8 imm=4; SW same fields; BEQ rs=1 rt=2 imm=0xFFFF.
  - Response: 0x8FA80004, 0xAFA80004, 0x1022FFFF at consecutive addresses.
- Backpressure: imem_ready=0 for 3 cycles during a pending write -> wr_en/addr/data stable, in_ready=0; write completes on the cycle imem_ready rises.
- Full and wrap:
  - Stimulus: DEPTH=4, base_addr=0xFE, 6 valid descriptors.
  - Response: addresses 0xFE, 0xFF, 0x00, 0x01; full=1; in_ready=0; descriptors 5-6 not accepted; start re-arms with count=0.
- Illegal kind and reset mid-op:
  - Stimulus: kind=6 -> bad_kind=1, no write, count unchanged. Then rst asserted while a write is pending.
  - Response: the write is never completed; all outputs return to reset values.
